// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus types: MemIO encodings, arbiter state and grant enums.
// Used by the memory arbiter, the ALU and the fetch unit.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        MEMIO_NONE  = 2'd0,
        MEMIO_READ  = 2'd1,
        MEMIO_WRITE = 2'd2
    } memio_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_ALU   = 1'b1
    } grant_e;

    // Code 3 is reserved and behaves like "no request".
    function automatic logic is_alu_req(input logic [1:0] io);
        return (io == MEMIO_READ) || (io == MEMIO_WRITE);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester, memory and status signals around the arbiter.
// master: arbiter view (drives memory + completions); slave: the rest.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;

    logic [1:0]        alu_mem_io;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_wdata;
    logic [DATA_W-1:0] alu_rdata;
    logic              alu_valid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              busy;
    logic              timeout_err;

    modport master (
        input  fetch_req, fetch_addr,
        input  alu_mem_io, alu_addr, alu_wdata,
        input  mem_rdata, mem_ready,
        output fetch_data, fetch_valid,
        output alu_rdata, alu_valid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, timeout_err
    );

    modport slave (
        output fetch_req, fetch_addr,
        output alu_mem_io, alu_addr, alu_wdata,
        output mem_rdata, mem_ready,
        input  fetch_data, fetch_valid,
        input  alu_rdata, alu_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, timeout_err
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker (req[0]=fetch, req[1]=ALU).
// Ports: req, last_grant in; grant, grant_valid out. Purely combinational.
module rr_arbiter2
    import cpu_bus_pkg::*;
(
    input  logic [1:0] req,
    input  grant_e     last_grant,
    output grant_e     grant,
    output logic       grant_valid
);

    always_comb begin
        grant       = GNT_FETCH;
        grant_valid = |req;
        unique case (req)
            2'b01:   grant = GNT_FETCH;
            2'b10:   grant = GNT_ALU;
            2'b11:   grant = (last_grant == GNT_FETCH) ? GNT_ALU : GNT_FETCH;
            default: grant = GNT_FETCH;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch and ALU with round-robin + watchdog.
// Ports: clk, rst_n (async low), bus (mem_bus_arbiter_if.master).
module mem_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_bus_arbiter_if.master  bus
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    // Last ACCESS cycle allowed: the abort fires on this cycle if no ready.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    grant_e            gnt_q, gnt_d;
    grant_e            last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              mem_en_q, mem_en_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;
    logic [DATA_W-1:0] adata_q, adata_d;
    logic              fvalid_q, fvalid_d;
    logic              avalid_q, avalid_d;
    logic              busy_q, busy_d;
    logic              terr_q, terr_d;

    logic              alu_req;
    grant_e            rr_grant;
    logic              rr_valid;
    logic              finish;
    logic [DATA_W-1:0] rdat;

    assign alu_req = is_alu_req(bus.alu_mem_io);

    rr_arbiter2 u_rr (
        .req         ({alu_req, bus.fetch_req}),
        .last_grant  (last_q),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        wdog_d   = wdog_q;
        mem_en_d = mem_en_q;
        fdata_d  = fdata_q;
        adata_d  = adata_q;
        fvalid_d = 1'b0;
        avalid_d = 1'b0;
        busy_d   = busy_q;
        terr_d   = terr_q;
        // A ready on the watchdog's last cycle still counts as success.
        finish   = bus.mem_ready || (wdog_q == WD_LAST);
        rdat     = bus.mem_ready ? bus.mem_rdata : '0;

        unique case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    gnt_d    = rr_grant;
                    wdog_d   = '0;
                    mem_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ACCESS;
                    if (rr_grant == GNT_ALU) begin
                        addr_d  = bus.alu_addr;
                        wdata_d = bus.alu_wdata;
                        we_d    = (bus.alu_mem_io == MEMIO_WRITE);
                    end else begin
                        addr_d  = bus.fetch_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (finish) begin
                    if (!we_q) begin
                        if (gnt_q == GNT_FETCH) fdata_d = rdat;
                        else                    adata_d = rdat;
                    end
                    if (!bus.mem_ready) terr_d = 1'b1;
                    fvalid_d = (gnt_q == GNT_FETCH);
                    avalid_d = (gnt_q == GNT_ALU);
                    mem_en_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            DONE: begin
                last_d  = gnt_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= GNT_FETCH;
            last_q   <= GNT_FETCH;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            wdog_q   <= '0;
            mem_en_q <= 1'b0;
            fdata_q  <= '0;
            adata_q  <= '0;
            fvalid_q <= 1'b0;
            avalid_q <= 1'b0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            wdog_q   <= wdog_d;
            mem_en_q <= mem_en_d;
            fdata_q  <= fdata_d;
            adata_q  <= adata_d;
            fvalid_q <= fvalid_d;
            avalid_q <= avalid_d;
            busy_q   <= busy_d;
            terr_q   <= terr_d;
        end
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.fetch_data  = fdata_q;
    assign bus.fetch_valid = fvalid_q;
    assign bus.alu_rdata   = adata_q;
    assign bus.alu_valid   = avalid_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cases plus random
// transactions checked against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    // Transaction-level model state
    bit          m_last_alu;
    logic [31:0] m_fdata;
    logic [31:0] m_adata;
    bit          m_terr;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_alu = 1'b0;
        m_fdata    = '0;
        m_adata    = '0;
        m_terr     = 1'b0;
    endtask

    task automatic drop_reqs();
        bus.fetch_req  = 1'b0;
        bus.alu_mem_io = 2'd0;
    endtask

    // Called at a negedge of an IDLE cycle; returns at a negedge of IDLE.
    // lat: ACCESS cycle (1-based) with mem_ready; 0 or >TO means never.
    task automatic txn(input bit fr, input logic [1:0] mio,
                       input logic [31:0] fa, input logic [31:0] aa,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int lat, input bit drop);
        bit          ar;
        bit          win_alu;
        bit          is_wr;
        bit          to;
        bit          done;
        logic [31:0] eaddr;
        logic [31:0] val;
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.alu_mem_io = mio;
        bus.alu_addr   = aa;
        bus.alu_wdata  = wd;
        bus.mem_ready  = 1'($urandom);
        bus.mem_rdata  = $urandom;
        ar = (mio == 2'd1) || (mio == 2'd2);
        if (!fr && !ar) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("idle_mem_en", bus.mem_en, 0);
                chk("idle_busy", bus.busy, 0);
                chk("idle_valids", {bus.fetch_valid, bus.alu_valid}, 0);
                bus.mem_ready = 1'($urandom);
            end
            drop_reqs();
            bus.mem_ready = 1'b0;
            return;
        end
        win_alu = (fr && ar) ? !m_last_alu : ar;
        is_wr   = win_alu && (mio == 2'd2);
        eaddr   = win_alu ? aa : fa;
        to      = 1'b0;
        done    = 1'b0;
        for (int k = 1; k <= TO && !done; k++) begin
            @(negedge clk);
            chk("acc_mem_en", bus.mem_en, 1);
            chk("acc_busy", bus.busy, 1);
            chk("acc_addr", bus.mem_addr, eaddr);
            chk("acc_we", bus.mem_we, is_wr);
            if (is_wr) chk("acc_wdata", bus.mem_wdata, wd);
            chk("acc_valids", {bus.fetch_valid, bus.alu_valid}, 0);
            if (drop && k == 1) begin
                drop_reqs();
                bus.fetch_addr = $urandom;
                bus.alu_addr   = $urandom;
                bus.alu_wdata  = $urandom;
            end
            if (k == lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rd;
                done = 1'b1;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
                if (k == TO) begin
                    done = 1'b1;
                    to   = 1'b1;
                end
            end
        end
        if (!is_wr) begin
            val = to ? 32'd0 : rd;
            if (win_alu) m_adata = val;
            else         m_fdata = val;
        end
        if (to) m_terr = 1'b1;
        @(negedge clk);
        chk("done_fvalid", bus.fetch_valid, !win_alu);
        chk("done_avalid", bus.alu_valid, win_alu);
        chk("done_mem_en", bus.mem_en, 0);
        chk("done_busy", bus.busy, 1);
        chk("done_fdata", bus.fetch_data, m_fdata);
        chk("done_adata", bus.alu_rdata, m_adata);
        chk("done_terr", bus.timeout_err, m_terr);
        drop_reqs();
        bus.mem_ready = 1'($urandom);
        bus.mem_rdata = $urandom;
        m_last_alu = win_alu;
        @(negedge clk);
        chk("post_valids", {bus.fetch_valid, bus.alu_valid}, 0);
        chk("post_busy", bus.busy, 0);
        chk("post_mem_en", bus.mem_en, 0);
        chk("post_fdata", bus.fetch_data, m_fdata);
        chk("post_adata", bus.alu_rdata, m_adata);
        bus.mem_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, bus.mem_en, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_fdata"}, bus.fetch_data, 0);
        chk({tag, "_adata"}, bus.alu_rdata, 0);
        chk({tag, "_valids"}, {bus.fetch_valid, bus.alu_valid}, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_terr"}, bus.timeout_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        rst_n = 1'b0;
        drop_reqs();
        bus.fetch_addr = '0;
        bus.alu_addr   = '0;
        bus.alu_wdata  = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention: both held, grants ALU, FETCH, ALU, FETCH
        for (int i = 0; i < 4; i++)
            txn(1, 2'd1, $urandom, $urandom, $urandom, $urandom, 1, 0);

        // Single ALU read
        txn(0, 2'd1, 0, 32'h100, 0, 32'h0000_00C7, 1, 0);
        chk("read_adata", bus.alu_rdata, 32'hC7);

        // ALU write, ready on third ACCESS cycle
        txn(0, 2'd2, 0, 32'h200, 32'hFA, $urandom, 3, 0);
        chk("write_adata", bus.alu_rdata, 32'hC7);

        // Ready exactly on the last watchdog cycle: normal completion
        txn(1, 2'd0, 32'h40, 0, 0, 32'h1234_5678, TO, 0);
        chk("edge_terr", bus.timeout_err, 0);

        // Requester drops mid-transaction
        txn(0, 2'd1, 0, 32'h300, 0, 32'hDEAD_BEEF, 2, 1);

        // Reserved MemIO code never grants
        txn(0, 2'd3, 0, 32'h400, 0, 0, 1, 0);

        // Timeout on a fetch
        txn(1, 2'd0, 32'h500, 0, 0, $urandom, 0, 0);
        chk("to_fdata", bus.fetch_data, 0);
        chk("to_terr", bus.timeout_err, 1);

        // Randomized traffic
        for (int i = 0; i < 40; i++)
            txn(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                $urandom, int'($urandom_range(0, TO + 1)),
                1'($urandom));
        chk("rand_terr", bus.timeout_err, 1);

        // Reset in the middle of ACCESS
        bus.fetch_req  = 1'b1;
        bus.alu_mem_io = 2'd1;
        @(negedge clk);
        chk("rst_pre_en", bus.mem_en, 1);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        drop_reqs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_post_valids", {bus.fetch_valid, bus.alu_valid}, 0);
            chk("rst_post_busy", bus.busy, 0);
        end

        // First tie after reset goes to ALU
        txn(1, 2'd1, 32'h600, 32'h700, 0, 32'h0BAD_F00D, 1, 0);
        chk("rst_tie_adata", bus.alu_rdata, 32'h0BAD_F00D);
        chk("rst_tie_fdata", bus.fetch_data, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the CPU's single memory port between instruction fetch (PC side) and ALU data accesses (MemIO/DataIO side). Grants one requester at a time with round-robin on contention, drives the memory bus for one transaction, and returns read data with a one-cycle valid pulse. That pulse is the ALU's `ValidMemData`. A watchdog aborts transactions the memory never acknowledges.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: maximum ACCESS cycles without `mem_ready` before abort (≥1).

- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `fetch_req`  in  1: fetch read request; level, held until `fetch_valid`.
- `fetch_addr`  in  ADDR_W: fetch address.
- `fetch_data`  out  DATA_W: fetched word; holds last value.
- `fetch_valid`  out  1: one-cycle completion pulse.
- `alu_mem_io`  in  2: 0 none, 1 read, 2 write, 3 reserved (treated as none). Level, held until `alu_valid`.
- `alu_addr`  in  ADDR_W: ALU access address.
- `alu_wdata`  in  DATA_W: ALU write data.
- `alu_rdata`  out  DATA_W: ALU read data; holds last read value, unchanged by writes.
- `alu_valid`  out  1: one-cycle completion pulse (read or write). This is `ValidMemData`.
- `mem_en`  out  1: memory access strobe.
- `mem_we`  out  1: 1 = write.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_rdata`  in  DATA_W: memory read data, valid when `mem_ready`=1.
- `mem_ready`  in  1: memory acknowledge.
- `busy`  out  1: high in ACCESS and DONE.
- `timeout_err`  out  1: sticky; set on any abort, cleared only by reset.

## Operation
- **States:** IDLE, ACCESS, DONE.
- **IDLE**
  - Samples `fetch_req` and `alu_req`, where `alu_req` = (`alu_mem_io`==1 or 2).
  - If exactly one requester is active, grant it.
  - If both are active, grant the one not granted last. `last_grant` resets to FETCH, so the first tie goes to the ALU.
  - On grant: latch address, write data and `we` (1 only for ALU write) into registers, clear the watchdog, go to ACCESS.
- **ACCESS**
  - `mem_en`=1; `mem_addr`, `mem_wdata` and `mem_we` are driven from the latched registers and stay stable.
  - On `mem_ready`=1: capture `mem_rdata` into the granted requester's data register (reads only), go to DONE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT, go to DONE, load 0 as read data (reads only), and set `timeout_err`.
- **DONE**
  - `mem_en`=0; the granted requester's valid pulse is high for exactly this cycle.
  - Update `last_grant`, go to IDLE.
- **Request handling**
  - Request inputs are not re-sampled while in ACCESS or DONE.
  - If a request drops mid-transaction, the transaction still completes and the valid pulse is still emitted.
- **Boundary cases**
  - `mem_ready` outside ACCESS is ignored.
  - `mem_ready` in the same cycle the watchdog hits TIMEOUT counts as a normal completion; `timeout_err` is not set.
  - `alu_mem_io`=3 never generates a grant.
- **Reset**
  - Reset mid-transaction aborts immediately (asynchronous).
  - No valid pulse is issued for the aborted transaction.

## Timing
- **Reset values:** all outputs 0 (`fetch_data`, `alu_rdata`, `mem_*`, the valid pulses, `busy`, `timeout_err`); state IDLE; watchdog 0.
- **Minimum latency:**
  - Request sampled at edge N.
  - `mem_en` high in cycle N+1.
  - If `mem_ready` is high in N+1, the valid pulse occurs in cycle N+2.
  - The next grant is sampled at the end of cycle N+3 (IDLE).
  - Latency is therefore 2 cycles from sample to valid, and 3 cycles between back-to-back grants.
- **Requester rule:** deassert or change the request at the edge ending the valid cycle, so IDLE never sees a stale request.
- **Timeout:** abort path gives valid TIMEOUT+1 cycles after grant.
- All outputs are registered; none is combinational from inputs.

## Structure
- **Shared package `cpu_bus_pkg`:**
  - MemIO encodings: `MEMIO_NONE`=0, `MEMIO_READ`=1, `MEMIO_WRITE`=2.
  - Arbiter state enum: IDLE/ACCESS/DONE.
  - Grant enum: `GNT_FETCH`/`GNT_ALU`.
  - These are shared with the ALU and the fetch unit.
- **Sub-module `rr_arbiter2`:**
  - Two-request round-robin.
  - Inputs: `req[1:0]`, `last_grant`. Outputs: `grant`, `grant_valid`.
  - Combinational; `last_grant` is held in the parent.
- The watchdog counter is inline, $clog2(TIMEOUT+1) bits wide.

## Test plan
- **Single ALU read:** `alu_mem_io`=1, `alu_addr`=0x100; memory answers `mem_ready`=1 the first ACCESS cycle with 0x000000C7 → `mem_en` for 1 cycle, `alu_valid` pulse 2 cycles after sample, `alu_rdata`=0xC7, `fetch_valid` stays 0.
- **ALU write:** `alu_mem_io`=2, `alu_addr`=0x200, `alu_wdata`=0xFA; `mem_ready` after 3 cycles → `mem_we`=1, `mem_wdata`=0xFA held stable for 3 ACCESS cycles, `alu_valid` pulse, `alu_rdata` unchanged.
- **Contention:** `fetch_req` and ALU read held continuously → grants ALU, FETCH, ALU, FETCH; 3 cycles between grants.
- **Timeout:** TIMEOUT=4, fetch read, `mem_ready` never asserted → `fetch_valid` at 5 cycles after grant, `fetch_data`=0, `timeout_err`=1 until reset.
- **Reset mid-ACCESS:** `rst_n` low during ACCESS → `mem_en`, `busy` and the valid pulses go 0 immediately; no valid pulse after release; next tie grants ALU.
- **Reserved code:** `alu_mem_io`=3 with no fetch request → stays IDLE, `mem_en`=0 indefinitely.
